// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enable simple dual-port RAM.
// Holds the clear/ready FSM encoding and the read-during-write mode codes.
package ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   function automatic int num_bytes(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Post-reset clear sequencer: walks every word once, then releases the user ports.
// The state is exported so checkers can bind to it directly.
module ram_clear_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_busy,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output state_e                state_o
);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_cnt_q <= clr_cnt_q + 1'b1;
               // The last word is written on this edge, so the user ports open next cycle.
               if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                  state_q <= ST_READY;
                  busy_q  <= 1'b0;
               end
            end
            ST_READY: begin
               state_q <= ST_READY;
            end
            default: begin
               state_q <= ST_CLEAR;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign init_busy = busy_q;
   assign clr_we    = (state_q == ST_CLEAR) && !rst;
   assign clr_addr  = clr_cnt_q;
   assign state_o   = state_q;

endmodule

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register and a self-clear of all words after reset.
module sdp_ram_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int BYTE_WIDTH = 8,
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = RDW_OLD,
   localparam int NUM_BYTES = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_busy,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_BYTES-1:0]  wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output state_e                dbg_state
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   ram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_ctrl (
      .clk       (clk),
      .rst       (rst),
      .init_busy (init_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .state_o   (dbg_state)
   );

   logic user_ok, wr_fire, rd_fire;
   assign user_ok = !init_busy && !rst;
   assign wr_fire = user_ok && wr_en;
   assign rd_fire = user_ok && rd_en;

   // Clear sequence owns the write port while it runs.
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [NUM_BYTES-1:0]  mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;
   assign mem_we    = clr_we || wr_fire;
   assign mem_addr  = clr_we ? clr_addr : wr_addr;
   assign mem_be    = clr_we ? {NUM_BYTES{1'b1}} : wr_be;
   assign mem_wdata = clr_we ? '0 : wr_data;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_be[i]) mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Array read is always read-first; write-first lanes are patched after the RAM register.
   logic [NUM_BYTES-1:0]  byp_be_d;
   logic [NUM_BYTES-1:0]  byp_be_q;
   logic [DATA_WIDTH-1:0] byp_data_q;
   logic [DATA_WIDTH-1:0] raw_q;
   logic                  v1_q;
   logic [DATA_WIDTH-1:0] word1;

   assign byp_be_d = (RDW_MODE == RDW_NEW && wr_fire && wr_addr == rd_addr) ? wr_be : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         raw_q      <= '0;
         byp_be_q   <= '0;
         byp_data_q <= '0;
      end else begin
         v1_q <= rd_fire;
         if (rd_fire) begin
            raw_q      <= mem[rd_addr];
            byp_be_q   <= byp_be_d;
            byp_data_q <= wr_data;
         end
      end
   end

   always_comb begin
      word1 = raw_q;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (byp_be_q[i]) word1[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] out_q;
         logic                  v2_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               out_q <= '0;
               v2_q  <= 1'b0;
            end else begin
               v2_q <= v1_q;
               if (v1_q) out_q <= word1;
            end
         end
         assign rd_data  = out_q;
         assign rd_valid = v2_q;
      end else begin : g_direct
         assign rd_data  = word1;
         assign rd_valid = v1_q;
      end
   endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed self-checking bench for sdp_ram_be: clear timing, byte lanes,
// read-during-write, streaming reads and reset during clear / in-flight reads.
module tb_sdp_ram_be;
   import ram_pkg::*;

   localparam int OUT_REG  = 0;
   localparam int RDW_MODE = RDW_OLD;
   localparam int LAT      = (OUT_REG != 0) ? 2 : 1;

   logic        clk;
   logic        rst;
   logic        init_busy;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   state_e      dbg_state;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];

   sdp_ram_be #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (8),
      .BYTE_WIDTH (8),
      .OUT_REG    (OUT_REG),
      .RDW_MODE   (RDW_MODE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_busy (init_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_be     (wr_be),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .dbg_state (dbg_state)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   // Called right after the edge that accepted a read.
   task automatic wait_read(input logic [31:0] e, input string tag);
      int n;
      n = 1;
      while (rd_valid !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, 32'(n), 32'(LAT));
      check({tag, "_data"}, rd_data, e);
      tick();
      check({tag, "_strobe"}, {31'd0, rd_valid}, 32'd0);
      check({tag, "_hold"}, rd_data, e);
   endtask

   task automatic read_check(input logic [7:0] a, input logic [31:0] e, input string tag);
      rd_en = 1'b1; rd_addr = a;
      tick();
      rd_en = 1'b0;
      wait_read(e, tag);
   endtask

   // Counts cycles until init_busy falls, noting any rd_valid seen meanwhile.
   task automatic count_clear(output int n, output int seen);
      n = 0; seen = 0;
      while (init_busy === 1'b1 && n < 1000) begin
         tick();
         n++;
         if (rd_valid === 1'b1) seen++;
      end
   endtask

   initial begin
      int n, seen, got, first, last;
      logic [31:0] d;

      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      tick();

      // 1/2) reset, clear length, user ports ignored during clear
      rst = 1'b1;
      tick();
      check("rst_busy", {31'd0, init_busy}, 32'd1);
      check("rst_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_data", rd_data, 32'h0);
      check("rst_state", 32'(dbg_state), 32'(ST_CLEAR));
      rst = 1'b0;
      wr_en = 1'b1; wr_addr = 8'h10; wr_be = 4'hF; wr_data = 32'hDEADBEEF;
      rd_en = 1'b1; rd_addr = 8'h10;
      count_clear(n, seen);
      wr_en = 1'b0; rd_en = 1'b0;
      check("clear_len", 32'(n), 32'd256);
      check("clear_no_rvalid", 32'(seen), 32'd0);
      check("ready_state", 32'(dbg_state), 32'(ST_READY));
      read_check(8'h00, 32'h0, "clr_00");
      read_check(8'h7F, 32'h0, "clr_7f");
      read_check(8'hFF, 32'h0, "clr_ff");
      read_check(8'h10, 32'h0, "clr_ign_wr");

      // 3) byte lanes
      write(8'h05, 4'hF, 32'h11223344);
      write(8'h05, 4'b0101, 32'hAABBCCDD);
      read_check(8'h05, 32'h11BB33DD, "be_merge");
      write(8'h05, 4'h0, 32'hFFFFFFFF);
      read_check(8'h05, 32'h11BB33DD, "be_zero");

      // 4) collision
      write(8'h20, 4'hF, 32'hCAFEF00D);
      wr_en = 1'b1; wr_addr = 8'h20; wr_be = 4'b0011; wr_data = 32'h01020304;
      rd_en = 1'b1; rd_addr = 8'h20;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      wait_read((RDW_MODE == RDW_NEW) ? 32'hCAFE0304 : 32'hCAFEF00D, "rdw");
      read_check(8'h20, 32'hCAFE0304, "rdw_after");

      // different addresses in the same cycle
      wr_en = 1'b1; wr_addr = 8'h30; wr_be = 4'hF; wr_data = 32'h55AA55AA;
      rd_en = 1'b1; rd_addr = 8'h05;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      wait_read(32'h11BB33DD, "indep_rd");
      read_check(8'h30, 32'h55AA55AA, "indep_wr");
      write(8'hFF, 4'hF, 32'h0BADCAFE);
      read_check(8'hFF, 32'h0BADCAFE, "top_addr");

      // 5) back-to-back reads
      for (int i = 0; i < 16; i++) begin
         d = {4{8'(i)}} ^ 32'h5A5A5A5A;
         write(8'(i), 4'hF, d);
         exp_q.push_back(d);
      end
      got = 0; first = -1; last = -1;
      for (int c = 0; c < 20; c++) begin
         rd_en = (c < 16);
         rd_addr = 8'(c);
         tick();
         if (rd_valid === 1'b1) begin
            got++;
            if (first < 0) first = c;
            last = c;
            if (exp_q.size() > 0) check("stream_data", rd_data, exp_q.pop_front());
         end
      end
      rd_en = 1'b0;
      check("stream_count", 32'(got), 32'd16);
      check("stream_gapless", 32'(last - first), 32'd15);
      check("stream_first", 32'(first), 32'(LAT - 1));

      // 6a) reset in the middle of clear restarts it
      write(8'h10, 4'hF, 32'h12345678);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (100) tick();
      check("mid_clear_busy", {31'd0, init_busy}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      count_clear(n, seen);
      check("restart_len", 32'(n), 32'd256);
      read_check(8'h10, 32'h0, "reclr_10");
      read_check(8'h05, 32'h0, "reclr_05");

      // 6b) reset with reads in flight
      rd_en = 1'b1; rd_addr = 8'h05;
      tick();
      rst = 1'b1;
      tick();
      check("inflight_valid", {31'd0, rd_valid}, 32'd0);
      rst = 1'b0;
      count_clear(n, seen);
      rd_en = 1'b0;
      check("inflight_len", 32'(n), 32'd256);
      check("inflight_no_rvalid", 32'(seen), 32'd0);
      read_check(8'h20, 32'h0, "reclr_20");

      // final report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
